regfile_write_arbiter: RTL

- Shares the register file's single write port among NUM_REQ requesters, for example the SHA-256 message-schedule unit, the compression round unit and the host writeback path.
- Uses round-robin arbitration with a valid/ack handshake.
- Provides a bulk-clear sequencer that zeroes registers 1..31 through the same write port.
- Exports a pending-write mask so read-side logic can stall on in-flight writes.

---
 rtl/regfile_write_arbiter.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Shares the single write port of the register file among NUM_REQ requesters
// (for example the SHA-256 message-schedule unit, the compression round unit
// and the host writeback path). Requesters are served round-robin with a
// valid/ack handshake. A bulk-clear sequencer can take over the same write
// port to zero registers 1..31. A combinational pending-write mask lets
// read-side logic stall on registers that have a write requested or in flight.
//
// Ports
//   clock            : system clock, all state changes on the rising edge
//   ctrl_reset       : synchronous active-low reset (0 = reset)
//   req_valid        : per-requester write request
//   req_addr         : packed target addresses, requester i in slice i
//   req_data         : packed write data, requester i in slice i
//   req_ack          : registered one-cycle acknowledge, at most one bit high
//   clear_start      : start a bulk clear (ignored while a clear is running)
//   clear_busy       : registered, high while the clear sequence owns the port
//   clear_done       : registered one-cycle pulse after the last clear write
//   ctrl_writeEnable : registered register-file write enable
//   ctrl_writeReg    : registered register-file write address
//   data_writeReg    : registered register-file write data
//   pending_mask     : combinational, bit r set while a write to r is
//                      requested or being presented to the register file
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clock,
    input  logic                          ctrl_reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ack,
    input  logic                          clear_start,
    output logic                          clear_busy,
    output logic                          clear_done,
    output logic                          ctrl_writeEnable,
    output logic [ADDR_WIDTH-1:0]         ctrl_writeReg,
    output logic [DATA_WIDTH-1:0]         data_writeReg,
    output logic [31:0]                   pending_mask
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [ADDR_WIDTH-1:0] FIRST_CLR_REG = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_CLR_REG  = ADDR_WIDTH'(31);

    // ST_FINISH is the cycle in which register 31 is being written; it
    // exists so that clear_done follows the final write by one cycle and
    // arbitration only restarts once clear_done is visible.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [PTR_W-1:0]        rr_ptr_r;
    logic [PTR_W-1:0]        rr_ptr_next_s;
    logic [ADDR_WIDTH-1:0]   clr_cnt_r;
    logic [ADDR_WIDTH-1:0]   clr_cnt_next_s;

    logic [NUM_REQ-1:0]      eligible_s;
    logic                    win_found_s;
    logic [PTR_W-1:0]        win_idx_s;
    logic [ADDR_WIDTH-1:0]   win_addr_s;
    logic [DATA_WIDTH-1:0]   win_data_s;

    logic [NUM_REQ-1:0]      ack_next_s;
    logic                    we_next_s;
    logic [ADDR_WIDTH-1:0]   wreg_next_s;
    logic [DATA_WIDTH-1:0]   wdata_next_s;
    logic                    busy_next_s;
    logic                    done_next_s;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------

    // Round-robin pick: first set bit of elig searching upward from ptr with
    // wrap-around at NUM_REQ. Returns {found, index}.
    function automatic logic [PTR_W:0] rr_pick(
        input logic [NUM_REQ-1:0] elig,
        input logic [PTR_W-1:0]   ptr
    );
        logic [PTR_W:0]   result;
        logic [PTR_W-1:0] sel;
        logic             found;
        int               idx;
        result = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            idx = (idx >= NUM_REQ) ? (idx - NUM_REQ) : idx;
            sel = PTR_W'(idx);
            if (!found && elig[sel]) begin
                found  = 1'b1;
                result = {1'b1, sel};
            end
        end
        return result;
    endfunction

    // One-hot decode of a register address onto the 32-entry mask.
    function automatic logic [31:0] addr_onehot(input logic [ADDR_WIDTH-1:0] addr);
        logic [31:0] vec;
        vec = 32'd0;
        for (int j = 0; j < 32; j++) begin
            if (addr == ADDR_WIDTH'(j)) begin
                vec[j] = 1'b1;
            end
        end
        return vec;
    endfunction

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------

    // A requester acked this cycle is masked so a held request is not granted
    // twice; its next request becomes eligible one cycle later.
    always_comb begin
        eligible_s               = req_valid & ~req_ack;
        {win_found_s, win_idx_s} = rr_pick(eligible_s, rr_ptr_r);
    end

    // Select address and data of the winning requester.
    always_comb begin
        win_addr_s = '0;
        win_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx_s == PTR_W'(i)) begin
                win_addr_s = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_data_s = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                win_addr_s = win_addr_s;
                win_data_s = win_data_s;
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------

    // Next state, clear counter and round-robin pointer.
    always_comb begin
        state_next_s   = state_r;
        clr_cnt_next_s = clr_cnt_r;
        rr_ptr_next_s  = rr_ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (clear_start) begin
                    // Clear wins over any simultaneous request.
                    state_next_s   = ST_CLEAR;
                    clr_cnt_next_s = FIRST_CLR_REG;
                end else if (win_found_s) begin
                    if (win_idx_s == PTR_W'(NUM_REQ - 1)) begin
                        rr_ptr_next_s = '0;
                    end else begin
                        rr_ptr_next_s = win_idx_s + PTR_W'(1);
                    end
                end else begin
                    rr_ptr_next_s = rr_ptr_r;
                end
            end
            ST_CLEAR: begin
                clr_cnt_next_s = clr_cnt_r + ADDR_WIDTH'(1);
                if (clr_cnt_r == LAST_CLR_REG) begin
                    state_next_s = ST_FINISH;
                end else begin
                    state_next_s = ST_CLEAR;
                end
            end
            ST_FINISH: begin
                state_next_s   = ST_IDLE;
                clr_cnt_next_s = FIRST_CLR_REG;
            end
            default: begin
                state_next_s   = ST_IDLE;
                clr_cnt_next_s = FIRST_CLR_REG;
                rr_ptr_next_s  = '0;
            end
        endcase
    end

    // Values the registered outputs take at the next clock edge.
    always_comb begin
        ack_next_s   = '0;
        we_next_s    = 1'b0;
        wreg_next_s  = '0;
        wdata_next_s = '0;
        busy_next_s  = 1'b0;
        done_next_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (clear_start) begin
                    busy_next_s = 1'b1;
                end else if (win_found_s) begin
                    ack_next_s   = NUM_REQ'(1) << win_idx_s;
                    // Register 0 is hard-wired zero: ack the request but
                    // suppress the write.
                    we_next_s    = (win_addr_s != '0);
                    wreg_next_s  = win_addr_s;
                    wdata_next_s = win_data_s;
                end else begin
                    we_next_s = 1'b0;
                end
            end
            ST_CLEAR: begin
                we_next_s   = 1'b1;
                wreg_next_s = clr_cnt_r;
                busy_next_s = 1'b1;
            end
            ST_FINISH: begin
                done_next_s = 1'b1;
            end
            default: begin
                we_next_s = 1'b0;
            end
        endcase
    end

    // State register, pointer, counter and all registered outputs.
    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            state_r          <= ST_IDLE;
            rr_ptr_r         <= '0;
            clr_cnt_r        <= FIRST_CLR_REG;
            req_ack          <= '0;
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= '0;
            data_writeReg    <= '0;
            clear_busy       <= 1'b0;
            clear_done       <= 1'b0;
        end else begin
            state_r          <= state_next_s;
            rr_ptr_r         <= rr_ptr_next_s;
            clr_cnt_r        <= clr_cnt_next_s;
            req_ack          <= ack_next_s;
            ctrl_writeEnable <= we_next_s;
            ctrl_writeReg    <= wreg_next_s;
            data_writeReg    <= wdata_next_s;
            clear_busy       <= busy_next_s;
            clear_done       <= done_next_s;
        end
    end

    // -------------------------------------------------------------------------
    // Pending-write mask
    // -------------------------------------------------------------------------

    // Outstanding requests plus the write currently on the port; register 0
    // never holds a pending write.
    always_comb begin
        pending_mask = 32'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !req_ack[i]) begin
                pending_mask = pending_mask | addr_onehot(req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
            end else begin
                pending_mask = pending_mask;
            end
        end
        if (ctrl_writeEnable) begin
            pending_mask = pending_mask | addr_onehot(ctrl_writeReg);
        end else begin
            pending_mask = pending_mask;
        end
        pending_mask[0] = 1'b0;
    end

endmodule
